sum_accumulator_64: RTL and testbench

//  Downstream consumer of ripple_adder_64. Takes the 65-bit result {CARRY,SUM} through a valid/ready handshake.

---
 rtl/sum_accumulator_64_pkg.sv | 17 +
 rtl/sum_accumulator_64_if.sv | 39 +++
 rtl/sum_accumulator_64_adder.sv | 28 ++
 rtl/sum_accumulator_64.sv | 127 ++++++++++++
 tb/tb_sum_accumulator_64.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_accumulator_64_pkg.sv
// -----------------------------------------------------------------------------
// sum_accumulator_64_pkg
// Shared definitions for the batch accumulator behind the 64-bit adder datapath:
//   ADD_W   - datapath width of ripple_adder_64
//   state_t - accumulator FSM state (IDLE / ACCUM / HOLD)
// -----------------------------------------------------------------------------
package sum_accumulator_64_pkg;

    localparam int ADD_W = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accumulator_64_if.sv
// -----------------------------------------------------------------------------
// sum_accumulator_64_if
// Handshake bundle for sum_accumulator_64.
//   Input side : IN_VALID, IN_READY, IN_SUM, IN_CARRY, CLEAR
//   Output side: OUT_VALID, OUT_READY, OUT_ACC, OUT_OVF, BEAT_CNT
// Modports:
//   master - producer/consumer around the block (drives IN_*, CLEAR, OUT_READY)
//   slave  - the accumulator itself
// -----------------------------------------------------------------------------
interface sum_accumulator_64_if #(
    parameter int ACC_W = 72,
    parameter int BATCH = 4
);
    import sum_accumulator_64_pkg::*;

    localparam int CNT_W = $clog2(BATCH + 1);

    logic             IN_VALID;
    logic             IN_READY;
    logic [ADD_W-1:0] IN_SUM;
    logic             IN_CARRY;
    logic             CLEAR;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [ACC_W-1:0] OUT_ACC;
    logic             OUT_OVF;
    logic [CNT_W-1:0] BEAT_CNT;

    modport master (
        output IN_VALID, IN_SUM, IN_CARRY, CLEAR, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_ACC, OUT_OVF, BEAT_CNT
    );

    modport slave (
        input  IN_VALID, IN_SUM, IN_CARRY, CLEAR, OUT_READY,
        output IN_READY, OUT_VALID, OUT_ACC, OUT_OVF, BEAT_CNT
    );

endinterface

// File: rtl/sum_accumulator_64_adder.sv
// -----------------------------------------------------------------------------
// ripple_adder_64
// 64-bit ripple-carry adder, no carry-in.
//   A, B  in  64  operands
//   SUM   out 64  A + B modulo 2^64
//   CARRY out 1   carry out of bit 63
// -----------------------------------------------------------------------------
module ripple_adder_64
    import sum_accumulator_64_pkg::*;
(
    input  logic [ADD_W-1:0] A,
    input  logic [ADD_W-1:0] B,
    output logic [ADD_W-1:0] SUM,
    output logic             CARRY
);

    always_comb begin : p_ripple
        logic v_c;
        v_c = 1'b0;
        SUM = '0;
        for (int unsigned i = 0; i < ADD_W; i++) begin
            SUM[i] = A[i] ^ B[i] ^ v_c;
            v_c    = (A[i] & B[i]) | (v_c & (A[i] ^ B[i]));
        end
        CARRY = v_c;
    end

endmodule

// File: rtl/sum_accumulator_64.sv
// -----------------------------------------------------------------------------
// sum_accumulator_64
// Accumulates BATCH adder results {IN_CARRY,IN_SUM} into an ACC_W-bit total and
// presents the batch total on an output handshake.
//   CLK    in  1  rising-edge clock
//   RESET  in  1  synchronous, active-high
//   bus    slave modport of sum_accumulator_64_if:
//          IN_VALID/IN_READY/IN_SUM/IN_CARRY - beat input handshake
//          CLEAR                             - discard partial batch
//          OUT_VALID/OUT_READY/OUT_ACC       - batch total handshake
//          OUT_OVF                           - sticky wrap flag of the total
//          BEAT_CNT                          - beats accepted in this batch
// Parameters: ACC_W >= 66, BATCH >= 1.
// -----------------------------------------------------------------------------
module sum_accumulator_64
    import sum_accumulator_64_pkg::*;
#(
    parameter int ACC_W = 72,
    parameter int BATCH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    sum_accumulator_64_if.slave  bus
);

    localparam int CNT_W = $clog2(BATCH + 1);
    localparam int UP_W  = ACC_W - ADD_W;
    localparam int HI_W  = UP_W + 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_count;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_hold;
    logic [ADD_W-1:0]   w_lo_sum;
    logic               w_lo_carry;
    logic [HI_W-1:0]    w_hi_sum;
    logic [ACC_W-1:0]   w_acc_next;

    // Low 64 bits go through the shared ripple adder; the upper slice absorbs
    // IN_CARRY plus the ripple carry, and its own carry-out marks a wrap.
    ripple_adder_64 u_adder (
        .A     (r_acc[ADD_W-1:0]),
        .B     (bus.IN_SUM),
        .SUM   (w_lo_sum),
        .CARRY (w_lo_carry)
    );

    always_comb begin
        w_hi_sum   = {1'b0, r_acc[ACC_W-1:ADD_W]} + HI_W'(bus.IN_CARRY) + HI_W'(w_lo_carry);
        w_acc_next = {w_hi_sum[UP_W-1:0], w_lo_sum};
    end

    always_comb begin
        w_hold     = (r_state == S_HOLD);
        w_in_ready = !w_hold && !bus.CLEAR;
        w_accept   = bus.IN_VALID && w_in_ready;
        w_last     = w_accept && (r_count == CNT_W'(BATCH - 1));
    end

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (bus.CLEAR) begin
                    w_state_next = S_IDLE;
                end else if (w_accept) begin
                    w_state_next = w_last ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (bus.OUT_READY) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs (total and flag are masked outside HOLD)
    always_comb begin
        bus.IN_READY  = w_in_ready;
        bus.OUT_VALID = w_hold;
        bus.OUT_ACC   = w_hold ? r_acc : '0;
        bus.OUT_OVF   = w_hold ? r_ovf : 1'b0;
        bus.BEAT_CNT  = r_count;
    end

    // Accumulator, overflow flag and beat counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_hold) begin
            if (bus.OUT_READY) begin
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_count <= '0;
            end
        end else if (bus.CLEAR) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= w_acc_next;
            r_ovf   <= r_ovf | w_hi_sum[UP_W];
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sum_accumulator_64.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator_64
// Self-checking bench for sum_accumulator_64: a 72-bit and a 66-bit instance
// (BATCH=4) checked against a plain-arithmetic batch-sum reference model.
// -----------------------------------------------------------------------------
module tb_sum_accumulator_64;

    localparam int BATCH = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    sum_accumulator_64_if #(.ACC_W(72), .BATCH(BATCH)) ifa ();
    sum_accumulator_64_if #(.ACC_W(66), .BATCH(BATCH)) ifb ();

    sum_accumulator_64 #(.ACC_W(72), .BATCH(BATCH)) dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
    sum_accumulator_64 #(.ACC_W(66), .BATCH(BATCH)) dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] q_m[$];   // beats of the batch currently being built

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] o_acc(input int s);
        return (s == 0) ? 128'(ifa.OUT_ACC) : 128'(ifb.OUT_ACC);
    endfunction
    function automatic logic [127:0] o_ovf(input int s);
        return (s == 0) ? 128'(ifa.OUT_OVF) : 128'(ifb.OUT_OVF);
    endfunction
    function automatic logic [127:0] o_valid(input int s);
        return (s == 0) ? 128'(ifa.OUT_VALID) : 128'(ifb.OUT_VALID);
    endfunction
    function automatic logic [127:0] o_ready(input int s);
        return (s == 0) ? 128'(ifa.IN_READY) : 128'(ifb.IN_READY);
    endfunction
    function automatic logic [127:0] o_cnt(input int s);
        return (s == 0) ? 128'(ifa.BEAT_CNT) : 128'(ifb.BEAT_CNT);
    endfunction

    // Reference: the batch total is the plain sum of the 65-bit beats;
    // the block returns it modulo 2^W and flags whether it reached 2^W.
    function automatic logic [127:0] m_total();
        logic [127:0] t;
        t = '0;
        foreach (q_m[i]) t += q_m[i];
        return t;
    endfunction
    function automatic int m_width(input int s);
        return (s == 0) ? 72 : 66;
    endfunction
    function automatic logic [127:0] m_acc(input int s);
        return m_total() & ((128'd1 << m_width(s)) - 128'd1);
    endfunction
    function automatic logic [127:0] m_ovf(input int s);
        return ((m_total() >> m_width(s)) != 0) ? 128'd1 : 128'd0;
    endfunction

    task automatic set_in(input int s, input logic v, input logic c, input logic [63:0] d, input logic clr);
        if (s == 0) begin
            ifa.IN_VALID = v; ifa.IN_CARRY = c; ifa.IN_SUM = d; ifa.CLEAR = clr;
        end else begin
            ifb.IN_VALID = v; ifb.IN_CARRY = c; ifb.IN_SUM = d; ifb.CLEAR = clr;
        end
    endtask

    task automatic set_ordy(input int s, input logic r);
        if (s == 0) ifa.OUT_READY = r;
        else        ifb.OUT_READY = r;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        for (int s = 0; s < 2; s++) begin
            set_in(s, 1'b0, 1'b0, 64'd0, 1'b0);
            set_ordy(s, 1'b0);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_out_valid", o_valid(s), 128'd0);
            chk("rst_beat_cnt",  o_cnt(s),   128'd0);
            chk("rst_in_ready",  o_ready(s), 128'd1);
            chk("rst_out_acc",   o_acc(s),   128'd0);
            chk("rst_out_ovf",   o_ovf(s),   128'd0);
        end
        q_m.delete();
    endtask

    // Present one beat, wait (bounded) for acceptance, then drop IN_VALID.
    task automatic send(input int s, input logic c, input logic [63:0] d, input int gap);
        int k;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        set_in(s, 1'b1, c, d, 1'b0);
        #1;
        k = 0;
        while (o_ready(s) != 128'd1 && k < 20) begin
            @(negedge CLK);
            #1;
            k++;
        end
        if (k == 20) begin
            n_tests++;
            n_fail++;
            $error("FAIL send_timeout: IN_READY stayed %0h, required 1", o_ready(s));
        end
        @(posedge CLK);
        q_m.push_back({63'd0, c, d});
        @(negedge CLK);
        set_in(s, 1'b0, 1'b0, 64'd0, 1'b0);
        #1;
        chk("beat_cnt",  o_cnt(s),   128'(q_m.size()));
        chk("out_valid", o_valid(s), (q_m.size() == BATCH) ? 128'd1 : 128'd0);
    endtask

    // Called right after the last accept: check the total, hold, then hand off.
    task automatic finish_batch(input int s, input int hold);
        logic [127:0] e_acc, e_ovf;
        e_acc = m_acc(s);
        e_ovf = m_ovf(s);
        chk("total_valid", o_valid(s), 128'd1);
        chk("total_acc",   o_acc(s),   e_acc);
        chk("total_ovf",   o_ovf(s),   e_ovf);
        chk("total_cnt",   o_cnt(s),   128'(BATCH));
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            #1;
            chk("hold_valid", o_valid(s), 128'd1);
            chk("hold_acc",   o_acc(s),   e_acc);
            chk("hold_ovf",   o_ovf(s),   e_ovf);
            chk("hold_ready", o_ready(s), 128'd0);
        end
        set_ordy(s, 1'b1);
        @(negedge CLK);
        set_ordy(s, 1'b0);
        #1;
        chk("done_valid", o_valid(s), 128'd0);
        chk("done_cnt",   o_cnt(s),   128'd0);
        chk("done_acc",   o_acc(s),   128'd0);
        chk("done_ovf",   o_ovf(s),   128'd0);
        chk("done_ready", o_ready(s), 128'd1);
        q_m.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            set_in(s, 1'b0, 1'b0, 64'd0, 1'b0);
            set_ordy(s, 1'b0);
        end
        repeat (2) @(negedge CLK);
        do_reset();

        // Small values: total 10
        for (int i = 1; i <= 4; i++) send(0, 1'b0, 64'(i), 0);
        chk("t1_total_10", o_acc(0), 128'd10);
        finish_batch(0, 0);

        // Maximum beats into 72 bits (no wrap) and into 66 bits (wrap)
        for (int i = 0; i < 4; i++) send(0, 1'b1, '1, 0);
        chk("t2_acc72", o_acc(0), 128'h7_FFFF_FFFF_FFFF_FFFC);
        finish_batch(0, 1);
        for (int i = 0; i < 4; i++) send(1, 1'b1, '1, 0);
        chk("t3_acc66", o_acc(1), 128'h3_FFFF_FFFF_FFFF_FFFC);
        chk("t3_ovf66", o_ovf(1), 128'd1);
        finish_batch(1, 1);

        // Long HOLD with a beat waiting; it is taken the cycle after hand-off
        send(0, 1'b0, 64'd10, 0);
        send(0, 1'b0, 64'd20, 1);
        send(0, 1'b0, 64'd30, 0);
        send(0, 1'b0, 64'd40, 2);
        set_in(0, 1'b1, 1'b0, 64'd3, 1'b0);
        finish_batch(0, 5);
        @(posedge CLK);
        q_m.push_back(128'd3);
        @(negedge CLK);
        set_in(0, 1'b0, 1'b0, 64'd0, 1'b0);
        #1;
        chk("t4_first_accept", o_cnt(0), 128'd1);
        for (int i = 0; i < 3; i++) send(0, 1'b0, 64'(100 + i), 0);
        finish_batch(0, 0);

        // CLEAR discards partial batch and blocks a simultaneous beat
        send(0, 1'b0, 64'd7, 0);
        send(0, 1'b0, 64'd7, 0);
        @(negedge CLK);
        set_in(0, 1'b1, 1'b0, 64'd9, 1'b1);
        #1;
        chk("t5_clear_ready", o_ready(0), 128'd0);
        @(negedge CLK);
        set_in(0, 1'b0, 1'b0, 64'd0, 1'b0);
        #1;
        chk("t5_clear_cnt", o_cnt(0), 128'd0);
        q_m.delete();
        for (int i = 0; i < 4; i++) send(0, 1'b0, 64'd5, 0);
        chk("t5_total_20", o_acc(0), 128'd20);
        finish_batch(0, 0);

        // RESET during ACCUM, then during HOLD
        send(0, 1'b0, 64'd50, 0);
        send(0, 1'b1, 64'd60, 0);
        do_reset();
        for (int i = 0; i < 4; i++) send(0, 1'b0, 64'd1, 0);
        chk("t6a_total_4", o_acc(0), 128'd4);
        finish_batch(0, 0);
        for (int i = 0; i < 4; i++) send(0, 1'b1, 64'(i), 0);
        do_reset();
        for (int i = 0; i < 4; i++) send(0, 1'b0, 64'd1, 0);
        chk("t6b_total_4", o_acc(0), 128'd4);
        finish_batch(0, 0);

        // Randomized batches on both widths
        for (int b = 0; b < 16; b++) begin
            int s;
            s = b % 2;
            for (int i = 0; i < BATCH; i++) begin
                send(s, 1'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 2)));
            end
            finish_batch(s, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
